// File: rtl/control_unit_if.sv
// control_unit_if: bundles the instruction/flag inputs and all datapath control strobes
// exchanged between the control unit and the datapath.
//   master : control unit side (consumes IR/CON_FF/stop, drives strobes, run, err)
//   slave  : datapath/environment side
interface control_unit_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        stop;
  // Bus-drive enables
  logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
  // Register load / increment strobes
  logic        MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, CONIn, RIn, IncPC;
  // Register-field selects
  logic        Gra, Grb, Grc;
  // Memory strobes and ALU selects
  logic        read, write;
  logic        add, subtract, andSignal, orSignal;
  // Status
  logic        run, err;

  modport master (
    input  IR, CON_FF, stop,
    output PCout, Zlowout, MDRout, Cout, BAout, Rout,
    output MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, CONIn, RIn, IncPC,
    output Gra, Grb, Grc, read, write, add, subtract, andSignal, orSignal, run, err
  );

  modport slave (
    output IR, CON_FF, stop,
    input  PCout, Zlowout, MDRout, Cout, BAout, Rout,
    input  MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, CONIn, RIn, IncPC,
    input  Gra, Grb, Grc, read, write, add, subtract, andSignal, orSignal, run, err
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: Moore sequencer for a simple load/store CPU datapath.
// Steps RST -> T0..T7 per instruction, decoding the opcode in IR[31:27] at T3.
//   clk : single clock, rising edge
//   clr : asynchronous active-high reset (forces RST, clears err)
//   cu  : control_unit_if.master -- IR, CON_FF, stop in; all strobes, run, err out
// MEM_WAIT (0..7) stretches memory states T1, ld-T6 and st-T7 to MEM_WAIT+1 cycles.
module control_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master cu
);
  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  state_e     state_q, state_d;
  state_e     fetch_st;
  logic [2:0] wait_q, wait_d;
  logic       err_q, err_d;
  logic [4:0] opcode;
  logic       is_alu;
  logic       last_wait;

  assign opcode    = cu.IR[31:27];
  assign is_alu    = (opcode == OpAdd) || (opcode == OpSub) || (opcode == OpAnd) ||
                     (opcode == OpOr);
  assign last_wait = (wait_q == WaitLast);
  // Every entry to T0 is an instruction boundary; a pending stop diverts it to HALT.
  assign fetch_st  = cu.stop ? StHalt : StT0;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      // RST lingers one extra cycle so the first T0 lands on the second edge.
      StRst: if (wait_q[0]) state_d = fetch_st;
      StT0:  state_d = StT1;
      StT1:  if (last_wait) state_d = StT2;
      StT2:  state_d = StT3;
      StT3: begin
        if (is_alu || (opcode == OpAddi) || (opcode == OpLd) || (opcode == OpSt) ||
            (opcode == OpBr)) begin
          state_d = StT4;
        end else if (opcode == OpNop) begin
          state_d = fetch_st;
        end else begin
          state_d = StHalt;
          if (opcode != OpHalt) err_d = 1'b1;
        end
      end
      StT4:  state_d = StT5;
      StT5:  state_d = ((opcode == OpLd) || (opcode == OpSt) || (opcode == OpBr)) ? StT6
                                                                                   : fetch_st;
      StT6: begin
        if (opcode == OpBr) state_d = fetch_st;
        else if ((opcode == OpSt) || last_wait) state_d = StT7;
      end
      StT7:  if ((opcode != OpSt) || last_wait) state_d = fetch_st;
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
    // Counter runs only while a state is held; any transition clears it.
    wait_d = ((state_d == state_q) && (state_q != StHalt)) ? wait_q + 3'd1 : 3'd0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StRst;
      wait_q  <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign cu.err = err_q;

  always_comb begin
    cu.PCout = 1'b0; cu.Zlowout = 1'b0; cu.MDRout = 1'b0; cu.Cout = 1'b0;
    cu.BAout = 1'b0; cu.Rout = 1'b0;
    cu.MARIn = 1'b0; cu.PCIn = 1'b0; cu.MDRIn = 1'b0; cu.IRIn = 1'b0; cu.YIn = 1'b0;
    cu.ZIn = 1'b0; cu.CONIn = 1'b0; cu.RIn = 1'b0; cu.IncPC = 1'b0;
    cu.Gra = 1'b0; cu.Grb = 1'b0; cu.Grc = 1'b0;
    cu.read = 1'b0; cu.write = 1'b0;
    cu.add = 1'b0; cu.subtract = 1'b0; cu.andSignal = 1'b0; cu.orSignal = 1'b0;
    cu.run = 1'b0;
    unique case (state_q)
      StT0: begin
        cu.run = 1'b1; cu.PCout = 1'b1; cu.MARIn = 1'b1; cu.IncPC = 1'b1; cu.ZIn = 1'b1;
      end
      StT1: begin
        cu.run = 1'b1; cu.Zlowout = 1'b1; cu.read = 1'b1; cu.MDRIn = 1'b1;
        cu.PCIn = last_wait;  // PC updated once, on the final wait cycle
      end
      StT2: begin
        cu.run = 1'b1; cu.MDRout = 1'b1; cu.IRIn = 1'b1;
      end
      StT3: begin
        cu.run = 1'b1;
        if (is_alu || (opcode == OpAddi)) begin
          cu.Grb = 1'b1; cu.Rout = 1'b1; cu.YIn = 1'b1;
        end else if ((opcode == OpLd) || (opcode == OpSt)) begin
          cu.Grb = 1'b1; cu.BAout = 1'b1; cu.YIn = 1'b1;
        end else if (opcode == OpBr) begin
          cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONIn = 1'b1;
        end
      end
      StT4: begin
        cu.run = 1'b1;
        if (is_alu) begin
          cu.Grc = 1'b1; cu.Rout = 1'b1; cu.ZIn = 1'b1;
          cu.add       = (opcode == OpAdd);
          cu.subtract  = (opcode == OpSub);
          cu.andSignal = (opcode == OpAnd);
          cu.orSignal  = (opcode == OpOr);
        end else if (opcode == OpBr) begin
          cu.PCout = 1'b1; cu.YIn = 1'b1;
        end else begin
          cu.Cout = 1'b1; cu.add = 1'b1; cu.ZIn = 1'b1;
        end
      end
      StT5: begin
        cu.run = 1'b1;
        if (opcode == OpBr) begin
          cu.Cout = 1'b1; cu.add = 1'b1; cu.ZIn = 1'b1;
        end else if ((opcode == OpLd) || (opcode == OpSt)) begin
          cu.Zlowout = 1'b1; cu.MARIn = 1'b1;
        end else begin
          cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.RIn = 1'b1;
        end
      end
      StT6: begin
        cu.run = 1'b1;
        if (opcode == OpLd) begin
          cu.read = 1'b1; cu.MDRIn = 1'b1;
        end else if (opcode == OpSt) begin
          cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRIn = 1'b1;
        end else if (cu.CON_FF) begin
          cu.Zlowout = 1'b1; cu.PCIn = 1'b1;
        end
      end
      StT7: begin
        cu.run = 1'b1;
        if (opcode == OpSt) begin
          cu.MDRout = 1'b1; cu.write = 1'b1;
        end else begin
          cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.RIn = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: two control units (MEM_WAIT 0 and 2) share one instruction program.
// A table-driven model expands each instruction into its per-cycle strobe pattern and queues
// it; a negedge monitor pops and compares one entry per cycle per DUT.
module tb_control_unit;
  localparam logic [4:0] OpLd = 5'b00000, OpSt = 5'b00010, OpAdd = 5'b00011;
  localparam logic [4:0] OpSub = 5'b00100, OpAnd = 5'b00101, OpOr = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100, OpBr = 5'b10011, OpNop = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  localparam logic [25:0] KPcOut = 26'd1 << 0,   KZlowOut = 26'd1 << 1;
  localparam logic [25:0] KMdrOut = 26'd1 << 2,  KCOut = 26'd1 << 3;
  localparam logic [25:0] KBaOut = 26'd1 << 4,   KRout = 26'd1 << 5;
  localparam logic [25:0] KMarIn = 26'd1 << 6,   KPcIn = 26'd1 << 7;
  localparam logic [25:0] KMdrIn = 26'd1 << 8,   KIrIn = 26'd1 << 9;
  localparam logic [25:0] KYIn = 26'd1 << 10,    KZIn = 26'd1 << 11;
  localparam logic [25:0] KConIn = 26'd1 << 12,  KRIn = 26'd1 << 13;
  localparam logic [25:0] KIncPc = 26'd1 << 14,  KGra = 26'd1 << 15;
  localparam logic [25:0] KGrb = 26'd1 << 16,    KGrc = 26'd1 << 17;
  localparam logic [25:0] KRead = 26'd1 << 18,   KWrite = 26'd1 << 19;
  localparam logic [25:0] KAdd = 26'd1 << 20,    KSub = 26'd1 << 21;
  localparam logic [25:0] KAnd = 26'd1 << 22,    KOr = 26'd1 << 23;
  localparam logic [25:0] KRun = 26'd1 << 24,    KErr = 26'd1 << 25;

  localparam int NoStop = 1000000;
  localparam int NoAbort = -1;

  logic clk, clr, stop, mon_en;
  int checks, failures;
  int mj, cur_n;

  logic [31:0] prog [128];
  logic        pcon [128];
  logic [25:0] exp0 [$];
  logic [25:0] exp1 [$];

  control_unit_if if0 ();
  control_unit_if if1 ();

  control_unit #(.MEM_WAIT(0)) dut0 (.clk(clk), .clr(clr), .cu(if0));
  control_unit #(.MEM_WAIT(2)) dut1 (.clk(clk), .clr(clr), .cu(if1));

  // Datapath stand-in: IR and the branch flag load when the DUT pulses IRIn.
  logic [31:0] ir0, ir1;
  logic        con0, con1;
  int          idx0, idx1;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      ir0 <= '0; con0 <= 1'b0; idx0 <= 0;
    end else if (if0.IRIn) begin
      ir0 <= prog[idx0]; con0 <= pcon[idx0]; idx0 <= idx0 + 1;
    end
  end

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      ir1 <= '0; con1 <= 1'b0; idx1 <= 0;
    end else if (if1.IRIn) begin
      ir1 <= prog[idx1]; con1 <= pcon[idx1]; idx1 <= idx1 + 1;
    end
  end

  assign if0.IR = ir0;  assign if0.CON_FF = con0;  assign if0.stop = stop;
  assign if1.IR = ir1;  assign if1.CON_FF = con1;  assign if1.stop = stop;

  wire [25:0] act0 = {if0.err, if0.run, if0.orSignal, if0.andSignal, if0.subtract, if0.add,
                      if0.write, if0.read, if0.Grc, if0.Grb, if0.Gra, if0.IncPC, if0.RIn,
                      if0.CONIn, if0.ZIn, if0.YIn, if0.IRIn, if0.MDRIn, if0.PCIn, if0.MARIn,
                      if0.Rout, if0.BAout, if0.Cout, if0.MDRout, if0.Zlowout, if0.PCout};
  wire [25:0] act1 = {if1.err, if1.run, if1.orSignal, if1.andSignal, if1.subtract, if1.add,
                      if1.write, if1.read, if1.Grc, if1.Grb, if1.Gra, if1.IncPC, if1.RIn,
                      if1.CONIn, if1.ZIn, if1.YIn, if1.IRIn, if1.MDRIn, if1.PCIn, if1.MARIn,
                      if1.Rout, if1.BAout, if1.Cout, if1.MDRout, if1.Zlowout, if1.PCout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0_trace @%0t: got %h expected nothing queued", $time, act0);
      end else check("dut0_trace", act0, exp0.pop_front());
      if (exp1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_trace @%0t: got %h expected nothing queued", $time, act1);
      end else check("dut1_trace", act1, exp1.pop_front());
    end
  end

  task automatic put(input int which, input logic [25:0] v);
    if (mj < cur_n) begin
      if (which == 0) exp0.push_back(v);
      else exp1.push_back(v);
    end
    mj++;
  endtask

  // Entry 0 is the cycle after the first edge following clr release (still RST).
  // Entry j is produced by an edge that sees stop=1 when j > s.
  task automatic build(input int which, input int mw, input int n, input int s);
    logic       err;
    bit         halted;
    int         k;
    logic [4:0] op;
    logic       c;
    logic [25:0] alu;
    mj = 0; cur_n = n; err = 1'b0; halted = 0; k = 0;
    put(which, '0);
    while (mj < n) begin
      if (halted || (mj > s)) begin
        halted = 1;
        put(which, err ? KErr : 26'd0);
        continue;
      end
      put(which, KRun | KPcOut | KMarIn | KIncPc | KZIn);
      for (int w = 0; w < mw; w++) put(which, KRun | KZlowOut | KRead | KMdrIn);
      put(which, KRun | KZlowOut | KRead | KMdrIn | KPcIn);
      put(which, KRun | KMdrOut | KIrIn);
      op = prog[k][31:27]; c = pcon[k]; k++;
      case (op)
        OpAdd, OpSub, OpAnd, OpOr: begin
          alu = (op == OpAdd) ? KAdd : (op == OpSub) ? KSub : (op == OpAnd) ? KAnd : KOr;
          put(which, KRun | KGrb | KRout | KYIn);
          put(which, KRun | KGrc | KRout | KZIn | alu);
          put(which, KRun | KZlowOut | KGra | KRIn);
        end
        OpAddi: begin
          put(which, KRun | KGrb | KRout | KYIn);
          put(which, KRun | KCOut | KAdd | KZIn);
          put(which, KRun | KZlowOut | KGra | KRIn);
        end
        OpLd, OpSt: begin
          put(which, KRun | KGrb | KBaOut | KYIn);
          put(which, KRun | KCOut | KAdd | KZIn);
          put(which, KRun | KZlowOut | KMarIn);
          if (op == OpLd) begin
            repeat (mw + 1) put(which, KRun | KRead | KMdrIn);
            put(which, KRun | KMdrOut | KGra | KRIn);
          end else begin
            put(which, KRun | KGra | KRout | KMdrIn);
            repeat (mw + 1) put(which, KRun | KMdrOut | KWrite);
          end
        end
        OpBr: begin
          put(which, KRun | KGra | KRout | KConIn);
          put(which, KRun | KPcOut | KYIn);
          put(which, KRun | KCOut | KAdd | KZIn);
          put(which, c ? (KRun | KZlowOut | KPcIn) : KRun);
        end
        OpNop: put(which, KRun);
        OpHalt: begin put(which, KRun); halted = 1; end
        default: begin put(which, KRun); err = 1'b1; halted = 1; end
      endcase
    end
  endtask

  function automatic logic [4:0] rand_op();
    int r;
    logic [4:0] op;
    r = $urandom_range(0, 99);
    if (r < 2) return OpHalt;
    if (r < 4) begin
      do op = 5'($urandom);
      while (op inside {OpLd, OpSt, OpAdd, OpSub, OpAnd, OpOr, OpAddi, OpBr, OpNop, OpHalt});
      return op;
    end
    case ($urandom_range(0, 8))
      0: return OpLd;   1: return OpSt;   2: return OpAdd;
      3: return OpSub;  4: return OpAnd;  5: return OpOr;
      6: return OpAddi; 7: return OpBr;   default: return OpNop;
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 128; i++) begin
      prog[i] = {rand_op(), 27'($urandom)};
      pcon[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic set_op(input int i, input logic [4:0] op, input logic c);
    prog[i][31:27] = op;
    pcon[i] = c;
  endtask

  task automatic run_phase(input int n, input int s, input int abort_at);
    clr = 1'b1; stop = 1'b0; mon_en = 1'b0;
    #1;
    check("reset_dut0", act0, '0);
    check("reset_dut1", act1, '0);
    exp0.delete(); exp1.delete();
    build(0, 0, n, s);
    build(1, 2, n, s);
    @(negedge clk); #1;
    clr = 1'b0; mon_en = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(negedge clk); #1;
      if (j == s) stop = 1'b1;
      if (j == abort_at) begin
        // dut1 (MEM_WAIT=2) sits mid-T6 of ld here; clr must drop strobes with no edge.
        check("pre_abort_read_mdrin", {24'd0, if1.read, if1.MDRIn}, 26'd3);
        mon_en = 1'b0;
        clr = 1'b1;
        #1;
        check("abort_dut1", act1, '0);
        check("abort_dut0", act0, '0);
        exp0.delete(); exp1.delete();
        return;
      end
    end
    mon_en = 1'b0;
    check("drain_dut0", 26'(exp0.size()), '0);
    check("drain_dut1", 26'(exp1.size()), '0);
  endtask

  initial begin
    checks = 0; failures = 0;
    clr = 1'b1; stop = 1'b0; mon_en = 1'b0;

    // Directed mix: every opcode class, br with both flag values, ending in halt.
    fill_random();
    set_op(0, OpAdd, 1'b0);  set_op(1, OpBr, 1'b1);   set_op(2, OpBr, 1'b0);
    set_op(3, OpLd, 1'b0);   set_op(4, OpSt, 1'b0);   set_op(5, OpAddi, 1'b0);
    set_op(6, OpSub, 1'b0);  set_op(7, OpAnd, 1'b0);  set_op(8, OpOr, 1'b0);
    set_op(9, OpNop, 1'b0);  set_op(10, OpHalt, 1'b0);
    run_phase(120, NoStop, NoAbort);

    // Illegal opcode: err sticks in HALT; the next phase's reset check sees it cleared.
    fill_random();
    set_op(0, 5'b11111, 1'b0);
    run_phase(14, NoStop, NoAbort);

    // stop raised while dut0 is in T4 of st: store completes, then HALT.
    fill_random();
    set_op(0, OpSt, 1'b0);
    run_phase(40, 5, NoAbort);

    // clr pulsed mid-T6 of ld on dut1.
    fill_random();
    set_op(0, OpLd, 1'b0);
    run_phase(11, NoStop, 10);

    repeat (4) begin
      fill_random();
      run_phase(200, NoStop, NoAbort);
    end
    repeat (3) begin
      fill_random();
      run_phase(150, $urandom_range(0, 100), NoAbort);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
